ksa_top_level: RTL and testbench

- Registered WIDTH-bit unsigned adder built on a Kogge-Stone parallel-prefix carry network.
- Computes {cout, sum} = a + b + cin.
- Used as the datapath adder wherever a fast full-width add with carry-in and carry-out is needed.
- Combinational prefix core, followed by an output register stage.

---
 rtl/ksa_pkg.sv | 13 +
 rtl/ksa_gp_cell.sv | 14 +
 rtl/ksa_top_level.sv | 119 +++++++++++
 tb/tb_ksa_top_level.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared constants for the Kogge-Stone adder slice.
// Build option: KSA_PIPE_EN splits the prefix network with a pipeline register.
package ksa_pkg;

   localparam int KSA_WIDTH = 32;
   localparam int LEVELS    = $clog2(KSA_WIDTH);

   // Prefix level whose outputs feed the mid-network pipeline register.
   function automatic int split_level(input int width);
      return $clog2(width) / 2;
   endfunction

endpackage

// File: rtl/ksa_gp_cell.sv
// Black cell of the prefix network: merges a high (G,P) span with the adjacent low span.
module ksa_gp_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g,
   output logic p
);

   assign g = g_hi | (p_hi & g_lo);
   assign p = p_hi & p_lo;

endmodule

// File: rtl/ksa_top_level.sv
// Registered WIDTH-bit Kogge-Stone adder computing {cout, sum} = a + b + cin.
// Build option: KSA_PIPE_EN adds a register after prefix level split_level(WIDTH).
module ksa_top_level
   import ksa_pkg::*;
#(
   parameter int WIDTH = KSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid
);

   localparam int NLEV  = $clog2(WIDTH);
   localparam int N     = WIDTH + 1;
   localparam int SPLIT = split_level(WIDTH);

   logic [WIDTH-1:0]          g_bit;
   logic [WIDTH-1:0]          p_bit;
   logic [NLEV:0][N-1:0]      g_lv;
   logic [NLEV:0][N-1:0]      p_lv;
   logic [NLEV-1:0][N-1:0]    g_cell;
   logic [NLEV-1:0][N-1:0]    p_cell;
   logic [WIDTH-1:0]          p_post;
   logic                      valid_post;
   logic [WIDTH-1:0]          sum_c;
   logic                      cout_c;

   assign g_bit = a & b;
   assign p_bit = a ^ b;

   // Node 0 is the virtual bit -1 carrying cin as a pure generate.
   assign g_lv[0] = {g_bit, cin};
   assign p_lv[0] = {p_bit, 1'b0};

   for (genvar k = 0; k < NLEV; k++) begin : g_level
      for (genvar j = 0; j < N; j++) begin : g_node
         if (j >= (1 << k)) begin : g_black
            ksa_gp_cell u_cell (
               .g_hi (g_lv[k][j]),
               .p_hi (p_lv[k][j]),
               .g_lo (g_lv[k][j - (1 << k)]),
               .p_lo (p_lv[k][j - (1 << k)]),
               .g    (g_cell[k][j]),
               .p    (p_cell[k][j])
            );
         end else begin : g_pass
            assign g_cell[k][j] = g_lv[k][j];
            assign p_cell[k][j] = p_lv[k][j];
         end
      end
   end

`ifdef KSA_PIPE_EN
   logic [N-1:0]     g_reg;
   logic [N-1:0]     p_reg;
   logic [WIDTH-1:0] pb_reg;
   logic             valid_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_reg     <= '0;
         p_reg     <= '0;
         pb_reg    <= '0;
         valid_reg <= 1'b0;
      end else begin
         g_reg     <= g_cell[SPLIT];
         p_reg     <= p_cell[SPLIT];
         pb_reg    <= p_bit;
         valid_reg <= in_valid;
      end
   end

   for (genvar k = 0; k < NLEV; k++) begin : g_link
      if (k == SPLIT) begin : g_cut
         assign g_lv[k+1] = g_reg;
         assign p_lv[k+1] = p_reg;
      end else begin : g_wire
         assign g_lv[k+1] = g_cell[k];
         assign p_lv[k+1] = p_cell[k];
      end
   end

   assign p_post     = pb_reg;
   assign valid_post = valid_reg;
`else
   for (genvar k = 0; k < NLEV; k++) begin : g_link
      assign g_lv[k+1] = g_cell[k];
      assign p_lv[k+1] = p_cell[k];
   end

   assign p_post     = p_bit;
   assign valid_post = in_valid;
`endif

   // Nodes 0..WIDTH-1 already span down to cin; the top node still needs cin folded in.
   assign sum_c  = p_post ^ g_lv[NLEV][WIDTH-1:0];
   assign cout_c = g_lv[NLEV][WIDTH] | (p_lv[NLEV][WIDTH] & g_lv[NLEV][0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= valid_post;
         if (valid_post) begin
            sum  <= sum_c;
            cout <= cout_c;
         end
      end
   end

endmodule

// File: tb/tb_ksa_top_level.sv
// Directed and random checks for ksa_top_level at WIDTH=32.
// Build option: KSA_PIPE_EN switches the expected latency to 2 cycles.
`timescale 1ns/1ps
module tb_ksa_top_level;

`ifdef KSA_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic [31:0] sum;
   logic        cout;
   logic        out_valid;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ksa_top_level #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum),
      .cout      (cout),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      #3;
      total_cnt++;
      if ({out_valid, cout, sum} !== 34'd0)
         $display("[TB] FAIL reset_state: got v=%0b c=%0b s=%h, want all zero", out_valid, cout, sum);
      else
         pass_cnt++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 1) @(negedge clk);
   endtask

   task automatic test_vectors();
      logic [31:0] va [7];
      logic [31:0] vb [7];
      logic        vc [7];
      logic [31:0] es [7];
      logic        ec [7];
      va = '{32'd18, 32'd18, 32'd10888, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vb = '{32'd999, 32'd999, 32'd98712, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      es = '{32'd1017, 32'd1018, 32'd109600, 32'h0, 32'h1, 32'hFFFFFFFE, 32'hFFFFFFFF};
      ec = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         repeat (LAT - 1) @(negedge clk);
         total_cnt++;
         if (out_valid !== 1'b1) $display("[TB] FAIL vec%0d_valid: got %0b want 1", i, out_valid);
         else pass_cnt++;
         total_cnt++;
         if (sum !== es[i]) $display("[TB] FAIL vec%0d_sum: got %h want %h", i, sum, es[i]);
         else pass_cnt++;
         total_cnt++;
         if (cout !== ec[i]) $display("[TB] FAIL vec%0d_cout: got %0b want %0b", i, cout, ec[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_gap();
      @(negedge clk);
      a = 32'h12345678; b = 32'h0FEDCBA9; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      a = 32'hDEADBEEF; b = 32'hDEADBEEF; cin = 1'b0; in_valid = 1'b0;
      repeat (LAT) @(negedge clk);
      // 0x12345678 + 0x0FEDCBA9 + 1 = 0x22222222 and must survive the idle cycle.
      total_cnt++;
      if (out_valid !== 1'b0) $display("[TB] FAIL gap_valid: got %0b want 0", out_valid);
      else pass_cnt++;
      total_cnt++;
      if ({cout, sum} !== {1'b0, 32'h22222222})
         $display("[TB] FAIL gap_hold: got c=%0b s=%h want c=0 s=22222222", cout, sum);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [33:0] q [$];
      logic [33:0] exp_item;
      logic [32:0] last = '0;
      logic        have_last = 1'b0;
      logic [32:0] res;
      int          errs = 0;
      repeat (LAT + 1) @(negedge clk);
      for (int t = 0; t < 10000 + LAT; t++) begin
         if (q.size() == LAT) begin
            exp_item = q.pop_front();
            if (exp_item[33]) begin
               last      = exp_item[32:0];
               have_last = 1'b1;
            end
            if (exp_item[33] || have_last) begin
               total_cnt++;
               if ({out_valid, cout, sum} !== {exp_item[33], last}) begin
                  errs++;
                  if (errs <= 10)
                     $display("[TB] FAIL b2b_cycle%0d: got v=%0b c=%0b s=%h want v=%0b c=%0b s=%h",
                              t, out_valid, cout, sum, exp_item[33], last[32], last[31:0]);
               end else pass_cnt++;
            end
         end
         if (t < 10000) begin
            a        = $urandom;
            b        = $urandom;
            cin      = 1'($urandom_range(0, 1));
            in_valid = (t % 97 != 50);
         end else begin
            in_valid = 1'b0;
         end
         res = {1'b0, a} + {1'b0, b} + {32'd0, cin};
         q.push_back({in_valid, res});
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      a = 32'hAAAA5555; b = 32'h5555AAAA; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, cout, sum} !== 34'd0)
         $display("[TB] FAIL midreset_clear: got v=%0b c=%0b s=%h want all zero", out_valid, cout, sum);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      a = 32'h80000000; b = 32'h80000000; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== (LAT == 1))
         $display("[TB] FAIL midreset_first_valid: got %0b want %0b", out_valid, (LAT == 1));
      else pass_cnt++;
      repeat (LAT - 1) @(negedge clk);
      total_cnt++;
      if ({out_valid, cout, sum} !== {1'b1, 1'b1, 32'h1})
         $display("[TB] FAIL midreset_result: got v=%0b c=%0b s=%h want v=1 c=1 s=00000001", out_valid, cout, sum);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_gap();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
